// File: rtl/nn_img_loader.sv
// Image buffer fill stage: packs PIX_PER_WORD pixels per word and writes
// i_num_words consecutive buffer words starting at i_base_addr.
module nn_img_loader #(
    parameter int DATA_WIDTH       = 8,
    parameter int ADDR_WIDTH       = 10,
    parameter int PIX_PER_WORD     = 6,
    parameter int TOTAL_DATA_WIDTH = DATA_WIDTH * PIX_PER_WORD
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_start,
    input  logic [ADDR_WIDTH-1:0]       i_base_addr,
    input  logic [ADDR_WIDTH-1:0]       i_num_words,
    input  logic                        i_pix_valid,
    input  logic [DATA_WIDTH-1:0]       i_pix_data,
    output logic                        o_pix_ready,
    output logic                        o_wr_en,
    output logic [ADDR_WIDTH-1:0]       o_wr_addr,
    output logic [TOTAL_DATA_WIDTH-1:0] o_wr_data,
    output logic                        o_busy,
    output logic                        o_done
);

    localparam int CW = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;

    typedef enum logic [1:0] {IDLE, FILL, LAST, DONE} state_t;

    state_t                      r_state, w_next;
    logic [ADDR_WIDTH-1:0]       r_addr;
    logic [ADDR_WIDTH-1:0]       r_num_words;
    logic [ADDR_WIDTH-1:0]       r_word_cnt;
    logic [CW-1:0]               r_pix_cnt;
    logic [TOTAL_DATA_WIDTH-1:0] r_pack;
    logic                        r_pix_ready;
    logic                        r_wr_en;
    logic [ADDR_WIDTH-1:0]       r_wr_addr;
    logic [TOTAL_DATA_WIDTH-1:0] r_wr_data;
    logic                        r_busy;
    logic                        r_done;

    logic                        w_accept;
    logic                        w_word_end;
    logic                        w_last_word;
    logic [TOTAL_DATA_WIDTH-1:0] w_word;

    // r_pix_ready is high exactly while the FSM sits in FILL
    assign w_accept    = r_pix_ready & i_pix_valid;
    assign w_word_end  = w_accept && (r_pix_cnt == CW'(PIX_PER_WORD - 1));
    assign w_last_word = (r_word_cnt == r_num_words - 1'b1);

    // Current pack buffer with the incoming pixel dropped into its slot
    always_comb begin
        w_word = r_pack;
        w_word[r_pix_cnt*DATA_WIDTH +: DATA_WIDTH] = i_pix_data;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (i_start) w_next = (i_num_words != '0) ? FILL : DONE;
            FILL: if (w_word_end && w_last_word) w_next = LAST;
            LAST: w_next = DONE;
            DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_num_words <= '0;
            r_word_cnt  <= '0;
            r_pix_cnt   <= '0;
            r_pack      <= '0;
            r_pix_ready <= 1'b0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_pix_ready <= (w_next == FILL);
            r_busy      <= (w_next == FILL) || (w_next == LAST);
            r_done      <= (w_next == DONE);
            r_wr_en     <= 1'b0;

            if (r_state == IDLE && i_start) begin
                r_addr      <= i_base_addr;
                r_num_words <= i_num_words;
                r_word_cnt  <= '0;
                r_pix_cnt   <= '0;
            end

            if (w_accept) begin
                if (w_word_end) begin
                    r_pix_cnt  <= '0;
                    r_wr_en    <= 1'b1;
                    r_wr_addr  <= r_addr;
                    r_wr_data  <= w_word;
                    r_addr     <= r_addr + 1'b1;
                    r_word_cnt <= r_word_cnt + 1'b1;
                end else begin
                    r_pix_cnt <= r_pix_cnt + 1'b1;
                    r_pack    <= w_word;
                end
            end
        end
    end

    assign o_pix_ready = r_pix_ready;
    assign o_wr_en     = r_wr_en;
    assign o_wr_addr   = r_wr_addr;
    assign o_wr_data   = r_wr_data;
    assign o_busy      = r_busy;
    assign o_done      = r_done;

endmodule

// File: tb/tb_nn_img_loader.sv
// Directed bench for nn_img_loader: packing, addressing, wrap, zero-length,
// mid-job reset and ignored restart.
module tb_nn_img_loader;

    logic        clk = 1'b0;
    logic        rst, start, pix_valid;
    logic [9:0]  base_addr, num_words;
    logic [7:0]  pix_data;
    logic        pix_ready, wr_en, busy, done;
    logic [9:0]  wr_addr;
    logic [47:0] wr_data;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    int          wr_cnt, done_cnt, done_cyc, busy_cnt, nordy_cnt;
    logic [9:0]  wr_addr_q [8];
    logic [47:0] wr_data_q [8];
    int          wr_cyc_q  [8];

    nn_img_loader dut (
        .i_clk(clk), .i_rst(rst), .i_start(start),
        .i_base_addr(base_addr), .i_num_words(num_words),
        .i_pix_valid(pix_valid), .i_pix_data(pix_data),
        .o_pix_ready(pix_ready), .o_wr_en(wr_en), .o_wr_addr(wr_addr),
        .o_wr_data(wr_data), .o_busy(busy), .o_done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wr_en) begin
            if (wr_cnt < 8) begin
                wr_addr_q[wr_cnt] = wr_addr;
                wr_data_q[wr_cnt] = wr_data;
                wr_cyc_q[wr_cnt]  = cyc;
            end
            wr_cnt = wr_cnt + 1;
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (busy) busy_cnt = busy_cnt + 1;
        if (busy && !pix_ready) nordy_cnt = nordy_cnt + 1;
    end

    task automatic clear_log();
        wr_cnt = 0; done_cnt = 0; done_cyc = -1; busy_cnt = 0; nordy_cnt = 0;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic start_job(input logic [9:0] b, input logic [9:0] n);
        start = 1'b1; base_addr = b; num_words = n;
        tick(1);
        start = 1'b0; base_addr = 10'h3AA; num_words = 10'h155;
    endtask

    // Holds valid until the pixel is taken, then drops it
    task automatic send_pix(input logic [7:0] d);
        int bound;
        bound = 0;
        pix_valid = 1'b1; pix_data = d;
        while (!pix_ready && bound < 50) begin
            tick(1); bound++;
        end
        tests++;
        if (!pix_ready) begin
            fails++;
            $display("FAIL send_pix_timeout: pix_ready=%0b required 1", pix_ready);
        end
        tick(1);
        pix_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int bound;
        bound = 0;
        while (done_cnt == 0 && bound < 100) begin
            tick(1); bound++;
        end
        tests++;
        if (done_cnt == 0) begin
            fails++;
            $display("FAIL %s_done_timeout: done_cnt=%0d required >0", name, done_cnt);
        end
        tick(4);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; pix_valid = 1'b0; pix_data = '0;
        base_addr = '0; num_words = '0;
        tick(3);
        rst = 1'b0;
        tests++;
        if ({pix_ready, wr_en, busy, done} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_flags: got %b required 0000", {pix_ready, wr_en, busy, done});
        end
        tests++;
        if (wr_addr !== 10'd0) begin
            fails++; $display("FAIL reset_addr: got %0d required 0", wr_addr);
        end
        tests++;
        if (wr_data !== 48'd0) begin
            fails++; $display("FAIL reset_data: got %h required 0", wr_data);
        end
        clear_log();
        tick(3);
        tests++;
        if (wr_cnt !== 0 || busy_cnt !== 0 || pix_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle: wr=%0d busy=%0d rdy=%b required 0 0 0", wr_cnt, busy_cnt, pix_ready);
        end
    endtask

    task automatic check_two_words(input string name, input logic [9:0] a0,
                                   input logic [47:0] d0, input logic [47:0] d1);
        tests++;
        if (wr_cnt !== 2) begin
            fails++; $display("FAIL %s_count: got %0d writes required 2", name, wr_cnt);
        end
        tests++;
        if (wr_addr_q[0] !== a0 || wr_data_q[0] !== d0) begin
            fails++;
            $display("FAIL %s_word0: got %0d/%h required %0d/%h", name, wr_addr_q[0], wr_data_q[0], a0, d0);
        end
        tests++;
        if (wr_addr_q[1] !== a0 + 10'd1 || wr_data_q[1] !== d1) begin
            fails++;
            $display("FAIL %s_word1: got %0d/%h required %0d/%h", name, wr_addr_q[1], wr_data_q[1], a0 + 10'd1, d1);
        end
        tests++;
        if (done_cnt !== 1 || done_cyc !== wr_cyc_q[1] + 1) begin
            fails++;
            $display("FAIL %s_done: got cnt=%0d cyc=%0d required cnt=1 cyc=%0d", name, done_cnt, done_cyc, wr_cyc_q[1] + 1);
        end
    endtask

    task automatic test_continuous();
        clear_log();
        start_job(10'd0, 10'd2);
        for (int i = 1; i <= 12; i++) send_pix(8'(i));
        wait_done("cont");
        check_two_words("cont", 10'd0, 48'h060504030201, 48'h0C0B0A090807);
        tests++;
        if (wr_cyc_q[1] - wr_cyc_q[0] !== 6) begin
            fails++; $display("FAIL cont_spacing: got %0d cycles required 6", wr_cyc_q[1] - wr_cyc_q[0]);
        end
        tests++;
        if (nordy_cnt !== 1) begin
            fails++; $display("FAIL cont_busy_not_ready: got %0d cycles required 1", nordy_cnt);
        end
    endtask

    task automatic test_gappy();
        int gaps [12] = '{0, 2, 1, 0, 3, 0, 1, 1, 0, 2, 0, 1};
        clear_log();
        start_job(10'd0, 10'd2);
        for (int i = 1; i <= 12; i++) begin
            send_pix(8'(i));
            tick(gaps[i-1]);
        end
        wait_done("gap");
        check_two_words("gap", 10'd0, 48'h060504030201, 48'h0C0B0A090807);
        tests++;
        if (nordy_cnt !== 1) begin
            fails++; $display("FAIL gap_ready_held: busy-not-ready %0d cycles required 1", nordy_cnt);
        end
    endtask

    task automatic test_wrap();
        clear_log();
        start_job(10'd1023, 10'd3);
        for (int i = 0; i < 18; i++) send_pix(8'(8'h31 + i));
        wait_done("wrap");
        tests++;
        if (wr_cnt !== 3) begin
            fails++; $display("FAIL wrap_count: got %0d required 3", wr_cnt);
        end
        tests++;
        if (wr_addr_q[0] !== 10'd1023 || wr_addr_q[1] !== 10'd0 || wr_addr_q[2] !== 10'd1) begin
            fails++;
            $display("FAIL wrap_addrs: got %0d,%0d,%0d required 1023,0,1", wr_addr_q[0], wr_addr_q[1], wr_addr_q[2]);
        end
        tests++;
        if (wr_data_q[2] !== 48'h4241403F3E3D) begin
            fails++; $display("FAIL wrap_data2: got %h required 4241403f3e3d", wr_data_q[2]);
        end
    endtask

    task automatic test_zero_len();
        int scyc;
        clear_log();
        pix_valid = 1'b1; pix_data = 8'hEE;
        start_job(10'd7, 10'd0);
        scyc = cyc;
        tick(5);
        pix_valid = 1'b0;
        tests++;
        if (done_cnt !== 1 || done_cyc !== scyc) begin
            fails++; $display("FAIL zero_done: got cnt=%0d cyc=%0d required cnt=1 cyc=%0d", done_cnt, done_cyc, scyc);
        end
        tests++;
        if (wr_cnt !== 0 || busy_cnt !== 0) begin
            fails++; $display("FAIL zero_quiet: got wr=%0d busy=%0d required 0 0", wr_cnt, busy_cnt);
        end
    endtask

    task automatic test_mid_reset();
        clear_log();
        start_job(10'd0, 10'd2);
        for (int i = 0; i < 3; i++) send_pix(8'(8'h11 + i));
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tests++;
        if (pix_ready !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL mrst_state: got rdy=%b busy=%b required 0 0", pix_ready, busy);
        end
        tick(8);
        tests++;
        if (wr_cnt !== 0 || done_cnt !== 0) begin
            fails++; $display("FAIL mrst_no_write: got wr=%0d done=%0d required 0 0", wr_cnt, done_cnt);
        end
        clear_log();
        start_job(10'd5, 10'd1);
        for (int i = 0; i < 6; i++) send_pix(8'(8'hA0 + i));
        wait_done("mrst");
        tests++;
        if (wr_cnt !== 1 || wr_addr_q[0] !== 10'd5 || wr_data_q[0] !== 48'hA5A4A3A2A1A0) begin
            fails++;
            $display("FAIL mrst_restart: got n=%0d %0d/%h required 1 5/a5a4a3a2a1a0", wr_cnt, wr_addr_q[0], wr_data_q[0]);
        end
    endtask

    task automatic test_restart_ignored();
        clear_log();
        start_job(10'd20, 10'd2);
        for (int i = 0; i < 12; i++) begin
            if (i == 4) begin
                start = 1'b1; base_addr = 10'd100; num_words = 10'd5;
            end
            send_pix(8'(8'h51 + i));
            start = 1'b0;
        end
        wait_done("rstrt");
        tick(10);
        check_two_words("rstrt", 10'd20, 48'h565554535251, 48'h5C5B5A595857);
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_gappy();
        test_wrap();
        test_zero_len();
        test_mid_reset();
        test_restart_ignored();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
